// File: rtl/led_scan_driver_if.sv
// Bundle between the value-producing datapath and the multiplexed
// seven-segment scan driver. The datapath side is the master; the driver
// (which also owns the board-facing segment/digit pins) is the slave.
interface led_scan_driver_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] data;       // nibble i -> digit i (digit 0 rightmost)
    logic [DIGITS-1:0]   dpIn;       // decimal point per digit, 1 = lit
    logic [DIGITS-1:0]   blankMask;  // 1 = digit forced dark
    logic                lzs;        // leading-zero suppression, used live
    logic                load;       // one-cycle capture strobe
    logic [7:0]          segOut;     // .gfedcba, active-high
    logic [DIGITS-1:0]   digOut;     // digit select, active-low
    logic                frameStart; // first cycle of slot 0
    logic                pending;    // captured value waiting for a frame boundary

    modport master (
        output data, dpIn, blankMask, lzs, load,
        input  segOut, digOut, frameStart, pending
    );

    modport slave (
        input  data, dpIn, blankMask, lzs, load,
        output segOut, digOut, frameStart, pending
    );
endinterface

// File: rtl/led_scan_driver.sv
// Multiplexed hex display driver for DIGITS common-cathode seven-segment
// digits. Each digit owns a slot of SCAN_DIV cycles; the first GHOST_CYC
// cycles of every slot keep all digits off so the previous digit's segment
// pattern cannot bleed into the next one. New values are captured on 'load'
// and only become visible at a frame boundary, so a frame never mixes old and
// new digits.
module led_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int GHOST_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    led_scan_driver_if.slave  bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Scan position
    logic [DIV_W-1:0]    div_reg, div_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic                tick;
    logic                boundary;

    // Values currently on display
    logic [4*DIGITS-1:0] act_data_reg, act_data_next;
    logic [DIGITS-1:0]   act_dp_reg, act_dp_next;
    logic [DIGITS-1:0]   act_blank_reg, act_blank_next;

    // Values captured by 'load', waiting for the next frame boundary
    logic [4*DIGITS-1:0] pend_data_reg, pend_data_next;
    logic [DIGITS-1:0]   pend_dp_reg, pend_dp_next;
    logic [DIGITS-1:0]   pend_blank_reg, pend_blank_next;
    logic                pending_reg, pending_next;

    // Registered pin drivers
    logic [7:0]          seg_reg, seg_next;
    logic [DIGITS-1:0]   dig_reg, dig_next;
    logic                frame_start_reg, frame_start_next;

    // Per-digit decoded pattern and leading-zero darkening
    logic [7:0]          seg_digit [DIGITS];
    logic [DIGITS-1:0]   lz_dark;

    // Hex nibble to .gfedcba pattern (bit 7, the dp, is added separately)
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Slot divider and digit index; a tick on the last digit is the frame boundary
    always_comb begin
        tick     = (div_reg == DIV_LAST);
        boundary = tick && (idx_reg == IDX_LAST);
        div_next = tick ? '0 : div_reg + 1'b1;
        idx_next = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    // Load capture and tear-free transfer to the active set at the frame boundary
    always_comb begin
        pend_data_next  = pend_data_reg;
        pend_dp_next    = pend_dp_reg;
        pend_blank_next = pend_blank_reg;
        pending_next    = pending_reg;
        act_data_next   = act_data_reg;
        act_dp_next     = act_dp_reg;
        act_blank_next  = act_blank_reg;

        if (bus.load) begin
            pend_data_next  = bus.data;
            pend_dp_next    = bus.dpIn;
            pend_blank_next = bus.blankMask;
            pending_next    = 1'b1;
        end

        if (boundary) begin
            // A load on the boundary cycle itself goes straight to the display
            if (bus.load) begin
                act_data_next  = bus.data;
                act_dp_next    = bus.dpIn;
                act_blank_next = bus.blankMask;
            end else if (pending_reg) begin
                act_data_next  = pend_data_reg;
                act_dp_next    = pend_dp_reg;
                act_blank_next = pend_blank_reg;
            end
            pending_next = 1'b0;
        end
    end

    // Leading-zero run from the most significant digit downwards; digit 0 is never darkened
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_dark = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run        = run & (act_data_next[4*i +: 4] == 4'h0) & ~act_dp_next[i];
            lz_dark[i] = run & (i != 0);
        end
    end

    // Segment pattern per digit, with blanking and suppression taking priority
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign seg_digit[gi] = (act_blank_next[gi] || (bus.lzs && lz_dark[gi]))
                                 ? 8'h00
                                 : {act_dp_next[gi], hex_to_seg(act_data_next[4*gi +: 4])};
        end
    endgenerate

    // Pin values for the coming cycle, computed from the coming scan position
    always_comb begin
        seg_next         = 8'h00;
        dig_next         = '1;
        frame_start_next = boundary;
        if (int'(div_next) >= GHOST_CYC) begin
            dig_next[idx_next] = 1'b0;
            seg_next           = seg_digit[idx_next];
        end
    end

    // Scan position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            idx_reg <= '0;
        end else begin
            div_reg <= div_next;
            idx_reg <= idx_next;
        end
    end

    // Active and pending display value registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_data_reg   <= '0;
            act_dp_reg     <= '0;
            act_blank_reg  <= '0;
            pend_data_reg  <= '0;
            pend_dp_reg    <= '0;
            pend_blank_reg <= '0;
            pending_reg    <= 1'b0;
        end else begin
            act_data_reg   <= act_data_next;
            act_dp_reg     <= act_dp_next;
            act_blank_reg  <= act_blank_next;
            pend_data_reg  <= pend_data_next;
            pend_dp_reg    <= pend_dp_next;
            pend_blank_reg <= pend_blank_next;
            pending_reg    <= pending_next;
        end
    end

    // Glitch-free registered pin drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg         <= 8'h00;
            dig_reg         <= '1;
            frame_start_reg <= 1'b0;
        end else begin
            seg_reg         <= seg_next;
            dig_reg         <= dig_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign bus.segOut     = seg_reg;
    assign bus.digOut     = dig_reg;
    assign bus.frameStart = frame_start_reg;
    assign bus.pending    = pending_reg;

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver with 4 digits, 4-cycle slots and 1 ghost cycle.
// Expected pin values are queued per cycle when a scenario is set up and
// popped one per clock as the display scans.
module tb_led_scan_driver;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int GHOST_CYC = 1;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_scan_driver_if #(.DIGITS(DIGITS)) bus();

    led_scan_driver #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .GHOST_CYC(GHOST_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   cyc;     // cycles since reset release; cycle 0 is the reset-state cycle
    int   checks;
    int   errors;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Queue the expected pins for the next n cycles, given the pattern each slot should show
    task automatic push_cycles(input int n, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] s [4];
        exp_t e;
        int c, pos, slot;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int j = 0; j < n; j++) begin
            c      = cyc + 1 + sb.size();
            pos    = c % SCAN_DIV;
            slot   = (c / SCAN_DIV) % DIGITS;
            e.c    = c;
            e.dig  = 4'hF;
            e.seg  = 8'h00;
            e.fs   = (c % FRAME == 0) && (c > 0);
            if (pos >= GHOST_CYC) begin
                e.dig[slot] = 1'b0;
                e.seg       = s[slot];
            end
            sb.push_back(e);
        end
    endtask

    task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm);
        bus.load      = 1'b1;
        bus.data      = d;
        bus.dpIn      = dp;
        bus.blankMask = bm;
        $display("cyc %0d load data=%h dp=%b blank=%b", cyc, d, dp, bm);
    endtask

    task automatic test_reset();
        exp_t e;
        bus.data = '0; bus.dpIn = '0; bus.blankMask = '0; bus.lzs = 1'b0; bus.load = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.segOut !== 8'h00) begin errors++; $display("FAIL reset_seg got %h want 00", bus.segOut); end
        checks++;
        if (bus.digOut !== 4'hF) begin errors++; $display("FAIL reset_dig got %b want 1111", bus.digOut); end
        checks++;
        if (bus.frameStart !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", bus.frameStart); end
        checks++;
        if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", bus.pending); end
        rst = 1'b0;
        cyc = 0;
        $display("reset released");
    endtask

    task automatic test_idle_scan();
        exp_t e;
        push_cycles(2*FRAME, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            checks++;
            if (bus.digOut !== e.dig || bus.segOut !== e.seg || bus.frameStart !== e.fs) begin
                errors++;
                $display("FAIL idle_scan cyc=%0d dig=%b want %b seg=%h want %h fs=%b want %b",
                         e.c, bus.digOut, e.dig, bus.segOut, e.seg, bus.frameStart, e.fs);
            end
        end
    endtask

    task automatic test_load_midframe();
        exp_t e;
        push_cycles(15, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
        push_cycles(FRAME, 8'h71, 8'hDB, 8'h77, 8'h06);
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            checks++;
            if (bus.digOut !== e.dig || bus.segOut !== e.seg || bus.frameStart !== e.fs) begin
                errors++;
                $display("FAIL load_midframe cyc=%0d dig=%b want %b seg=%h want %h fs=%b want %b",
                         e.c, bus.digOut, e.dig, bus.segOut, e.seg, bus.frameStart, e.fs);
            end
            if (cyc == 38 || cyc == 47 || cyc == 48) begin
                checks++;
                if (bus.pending !== (cyc != 48)) begin
                    errors++;
                    $display("FAIL load_midframe_pending cyc=%0d got %b want %b", cyc, bus.pending, cyc != 48);
                end
            end
            if (cyc == 37) drive_load(16'h1A2F, 4'b0010, 4'b0000);
            else bus.load = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        push_cycles(FRAME, 8'h71, 8'hDB, 8'h77, 8'h06);
        push_cycles(FRAME, 8'h5B, 8'h5B, 8'h5B, 8'h5B);
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            checks++;
            if (bus.digOut !== e.dig || bus.segOut !== e.seg || bus.frameStart !== e.fs) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d dig=%b want %b seg=%h want %h fs=%b want %b",
                         e.c, bus.digOut, e.dig, bus.segOut, e.seg, bus.frameStart, e.fs);
            end
            if (cyc == 67 || cyc == 79 || cyc == 80) begin
                checks++;
                if (bus.pending !== (cyc != 80)) begin
                    errors++;
                    $display("FAIL back_to_back_pending cyc=%0d got %b want %b", cyc, bus.pending, cyc != 80);
                end
            end
            if (cyc == 66) drive_load(16'h1111, 4'b0000, 4'b0000);
            else if (cyc == 70) drive_load(16'h2222, 4'b0000, 4'b0000);
            else bus.load = 1'b0;
        end
    endtask

    task automatic test_load_at_boundary();
        exp_t e;
        drive_load(16'h0008, 4'b0000, 4'b0000);   // cycle 95: sampled on the boundary edge
        push_cycles(FRAME, 8'h7F, 8'h3F, 8'h3F, 8'h3F);
        while (sb.size() > 0) begin
            step();
            bus.load = 1'b0;
            e = sb.pop_front();
            checks++;
            if (bus.digOut !== e.dig || bus.segOut !== e.seg || bus.frameStart !== e.fs) begin
                errors++;
                $display("FAIL load_at_boundary cyc=%0d dig=%b want %b seg=%h want %h fs=%b want %b",
                         e.c, bus.digOut, e.dig, bus.segOut, e.seg, bus.frameStart, e.fs);
            end
            if (cyc == 96 || cyc == 100) begin
                checks++;
                if (bus.pending !== 1'b0) begin
                    errors++;
                    $display("FAIL load_at_boundary_pending cyc=%0d got %b want 0", cyc, bus.pending);
                end
            end
        end
    endtask

    task automatic test_lzs_blank();
        exp_t e;
        bus.lzs = 1'b1;
        push_cycles(FRAME, 8'h7F, 8'h00, 8'h00, 8'h00);
        push_cycles(FRAME, 8'h3F, 8'h6D, 8'h00, 8'h00);
        push_cycles(FRAME, 8'h00, 8'h6D, 8'h00, 8'h00);
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            checks++;
            if (bus.digOut !== e.dig || bus.segOut !== e.seg || bus.frameStart !== e.fs) begin
                errors++;
                $display("FAIL lzs_blank cyc=%0d dig=%b want %b seg=%h want %h fs=%b want %b",
                         e.c, bus.digOut, e.dig, bus.segOut, e.seg, bus.frameStart, e.fs);
            end
            if (cyc == 115) drive_load(16'h0050, 4'b0000, 4'b0000);
            else if (cyc == 135) drive_load(16'h0050, 4'b0000, 4'b0001);
            else bus.load = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        push_cycles(10, 8'h00, 8'h6D, 8'h00, 8'h00);
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            checks++;
            if (bus.digOut !== e.dig || bus.segOut !== e.seg || bus.frameStart !== e.fs) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d dig=%b want %b seg=%h want %h fs=%b want %b",
                         e.c, bus.digOut, e.dig, bus.segOut, e.seg, bus.frameStart, e.fs);
            end
            if (cyc == 168) drive_load(16'h1234, 4'b0000, 4'b0000);
            else bus.load = 1'b0;
        end
        checks++;
        if (bus.pending !== 1'b1) begin errors++; $display("FAIL pre_reset_pending got %b want 1", bus.pending); end

        // Cycle 169 is mid slot 2; reset acts without waiting for a clock edge
        rst = 1'b1;
        #1;
        checks++;
        if (bus.digOut !== 4'hF) begin errors++; $display("FAIL midreset_dig got %b want 1111", bus.digOut); end
        checks++;
        if (bus.segOut !== 8'h00) begin errors++; $display("FAIL midreset_seg got %h want 00", bus.segOut); end
        checks++;
        if (bus.pending !== 1'b0) begin errors++; $display("FAIL midreset_pending got %b want 0", bus.pending); end
        $display("reset asserted mid slot 2");

        bus.lzs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        push_cycles(FRAME, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            checks++;
            if (bus.digOut !== e.dig || bus.segOut !== e.seg || bus.frameStart !== e.fs) begin
                errors++;
                $display("FAIL post_reset cyc=%0d dig=%b want %b seg=%h want %h fs=%b want %b",
                         e.c, bus.digOut, e.dig, bus.segOut, e.seg, bus.frameStart, e.fs);
            end
        end
        checks++;
        if (bus.pending !== 1'b0) begin errors++; $display("FAIL post_reset_pending got %b want 0", bus.pending); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_idle_scan();        // ends at cycle 32
        test_load_midframe();    // ends at cycle 63
        test_back_to_back();     // ends at cycle 95
        test_load_at_boundary(); // ends at cycle 111
        test_lzs_blank();        // ends at cycle 159
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Multiplexed hex display driver for a bank of common-cathode seven-segment digits; parametrised successor to the single-digit static display path. It time-multiplexes `DIGITS` hex nibbles onto one shared segment bus, with per-digit decimal point, blanking mask, optional leading-zero suppression and frame-synchronous (tear-free) data update. It sits between the datapath that produces display values and the board segment/digit pins.

## Interface
- `DIGITS`, 8: number of digits driven (2..8).
- `SCAN_DIV`, 50000: clk cycles per digit slot (≥ 4).
- `GHOST_CYC`, 2: cycles at the start of each slot with all digits off (anti-ghosting), 0 ≤ GHOST_CYC < SCAN_DIV.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `data` in 4*DIGITS: hex values; nibble i drives digit i (digit 0 = rightmost, `digOut[0]`).
- `dpIn` in DIGITS: decimal point per digit, 1 = lit.
- `blankMask` in DIGITS: 1 = digit i forced dark (segments 0).
- `lzs` in 1: 1 = leading-zero suppression enabled.
- `load` in 1: one-cycle strobe; capture `data`/`dpIn`/`blankMask` for display.
- `segOut` out 8: segment bus `.gfedcba`, active-high.
- `digOut` out DIGITS: digit select, active-low, at most one bit low.
- `frameStart` out 1: one-cycle pulse when scan wraps to digit 0.
- `pending` out 1: a loaded value awaits the next frame boundary.

## Operation
- Reset, async on `rst` high: divider=0, index=0, active and pending registers=0, `pending`=0, `segOut`=8'h00, `digOut`=all ones, `frameStart`=0.
- Divider counts 0..SCAN_DIV-1; at count SCAN_DIV-1 (tick) it wraps to 0 and index advances; index DIGITS-1 wraps to 0.
- Tick with index wrap (DIGITS-1 → 0) = frame boundary: `frameStart` pulses; active registers update.
- Load handshake: `load` high copies inputs into pending registers and sets `pending`. Repeated loads before a boundary overwrite (newest wins).
- At frame boundary: if `load` is high that same cycle, active ← live inputs directly; else if `pending`, active ← pending registers. `pending` clears at the boundary in both cases.
- Decode per digit: standard hex table 0..F (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71); bit 7 = active dp.
- Blanking priority: blankMask bit → segments 8'h00 (dp also off). LZS: digit i>0 dark (8'h00, dp off) when lzs=1 and active nibbles i..DIGITS-1 are all zero and no active dp set among them; digit 0 never suppressed.
- Blanked digits still get their slot (duty cycle constant); `digOut` bit still driven low.
- `lzs` is sampled live (not via load).

## Timing
- `segOut`, `digOut` registered; slot k begins the cycle after the tick that sets index=k.
- For the first GHOST_CYC cycles of each slot: `digOut`=all ones, `segOut`=8'h00. Remaining SCAN_DIV-GHOST_CYC cycles: `digOut[k]`=0, others 1, `segOut`=decode of digit k.
- Full frame = DIGITS*SCAN_DIV cycles.
- `frameStart` registered, high for exactly the first cycle of slot 0.
- Display reflects a load at most one frame + 1 cycle later; `pending` rises the cycle after `load`.
- `rst` mid-frame: all state returns to reset values immediately; scan restarts at digit 0 after release, first `frameStart` after one full frame.

## Test plan
DIGITS=4, SCAN_DIV=4, GHOST_CYC=1 unless noted.
- Reset then run with no load -> `digOut` cycles 1110,1101,1011,0111 (each 3 cycles after 1 cycle 1111); `segOut`=3F every lit cycle; `frameStart` every 16 cycles.
- load data=16'h1A2F, dpIn=4'b0010 mid-frame -> `pending`=1 until boundary; next frame digits 0..3 show 71, 5B|80=DB, 77, 06.
- Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows all 5B; 1111 never displayed.
- load coincident with boundary tick, data=16'h0008 -> that frame shows 7F on digit 0; `pending`=0 after.
- lzs=1, data=16'h0050 -> digits 3,2 segOut 00, digit 1 = 6D, digit 0 = 3F; blankMask=4'b0001 -> digit 0 = 00.
- Assert `rst` mid slot 2 -> `digOut`=1111, `segOut`=00 same cycle; after release scan starts at digit 0, displayed value 0.
